// File: rtl/c7seg_capture.sv
// Purpose : recovers per-digit hex values from a multiplexed, active-low 7-segment bus.
// Latency : a bus value first seen at edge E and then held is captured at edge E+STABLE.
// Backpressure: none. The bus is observed passively, and captures happen only after a stable window.
//
// Ports:
//   clk      - system clock, rising edge
//   reset    - synchronous active-low reset
//   an       - digit strobes, active-low, bit i selects digit i
//   seg      - segment lines a..g on bits 6..0, active-low
//   o_digits - recovered hex value of digit i in bits [4i+3:4i]
//   o_valid  - digit i holds a legally decoded value
//   o_err    - last capture on digit i was an illegal, non-blank pattern
//   o_frame  - one-cycle pulse once every digit has been captured since the last pulse
module c7seg_capture #(
  parameter int NDIG   = 4,
  parameter int STABLE = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NDIG-1:0]     an,
  input  logic [6:0]          seg,
  output logic [4*NDIG-1:0]   o_digits,
  output logic [NDIG-1:0]     o_valid,
  output logic [NDIG-1:0]     o_err,
  output logic                o_frame
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  // Capture fires when the counter reaches STABLE-1. The edge that loads a new
  // bus value clears the counter, so the bus must be held for STABLE edges after that one.
  localparam logic [7:0] STABLE_M1 = 8'(STABLE - 1);

  state_t            state_q;
  logic [NDIG-1:0]   r_an_q;
  logic [6:0]        r_seg_q;
  logic [7:0]        cnt_q;
  logic [7:0]        cnt_d;
  logic [NDIG-1:0]   mask_q;
  logic [NDIG-1:0]   mask_d;
  logic              changed;
  logic              r_single;
  logic              in_single;
  logic [3:0]        dec_val;
  logic              dec_legal;
  logic              dec_blank;

  // True when exactly one strobe is low, meaning exactly one digit is addressed.
  function automatic logic one_low(input logic [NDIG-1:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < NDIG; i++) begin
      if (!v[i]) n = n + 4'd1;
    end
    return (n == 4'd1);
  endfunction

  assign changed   = ({an, seg} != {r_an_q, r_seg_q});
  assign r_single  = one_low(r_an_q);
  assign in_single = one_low(an);

  // The counter saturates at 255, so a long-held bus cannot wrap and re-trigger.
  assign cnt_d = changed ? 8'd0 : ((cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1);

  // With a single strobe, ~r_an_q is the one-hot mask bit of the digit being captured.
  assign mask_d = mask_q | ~r_an_q;

  // This is the inverse of the hex-to-7-segment table, with segments a..g active-low.
  always_comb begin
    dec_val   = 4'h0;
    dec_legal = 1'b1;
    dec_blank = 1'b0;
    case (r_seg_q)
      7'b0000001: dec_val = 4'h0;
      7'b1001111: dec_val = 4'h1;
      7'b0010010: dec_val = 4'h2;
      7'b0000110: dec_val = 4'h3;
      7'b1001100: dec_val = 4'h4;
      7'b0100100: dec_val = 4'h5;
      7'b0100000: dec_val = 4'h6;
      7'b0001111: dec_val = 4'h7;
      7'b0000000: dec_val = 4'h8;
      7'b0000100: dec_val = 4'h9;
      7'b0001000: dec_val = 4'hA;
      7'b1100000: dec_val = 4'hB;
      7'b0110001: dec_val = 4'hC;
      7'b1000010: dec_val = 4'hD;
      7'b0110000: dec_val = 4'hE;
      7'b0111000: dec_val = 4'hF;
      7'b1111111: begin
        dec_legal = 1'b0;
        dec_blank = 1'b1;
      end
      default:    dec_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      r_an_q   <= '0;
      r_seg_q  <= '0;
      cnt_q    <= 8'd0;
      mask_q   <= '0;
      o_digits <= '0;
      o_valid  <= '0;
      o_err    <= '0;
      o_frame  <= 1'b0;
    end else begin
      r_an_q  <= an;
      r_seg_q <= seg;
      cnt_q   <= cnt_d;
      o_frame <= 1'b0;

      if (changed) begin
        // The validity of the new strobe pattern decides whether a new stable window can start.
        state_q <= in_single ? SETTLE : IDLE;
      end else if (!r_single) begin
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE, SETTLE: begin
            if (cnt_q == STABLE_M1) begin
              state_q <= HOLD;
              for (int i = 0; i < NDIG; i++) begin
                if (!r_an_q[i]) begin
                  if (dec_legal) begin
                    o_digits[4*i +: 4] <= dec_val;
                    o_valid[i]         <= 1'b1;
                    o_err[i]           <= 1'b0;
                  end else if (dec_blank) begin
                    o_valid[i] <= 1'b0;
                    o_err[i]   <= 1'b0;
                  end else begin
                    o_valid[i] <= 1'b0;
                    o_err[i]   <= 1'b1;
                  end
                end
              end
              // When the final digit completes the frame, the mask restarts empty.
              // The digit that completed the frame does not count toward the next frame.
              if (&mask_d) begin
                o_frame <= 1'b1;
                mask_q  <= '0;
              end else begin
                mask_q  <= mask_d;
              end
            end else begin
              state_q <= SETTLE;
            end
          end
          // A window that has already been captured waits for the bus to change.
          HOLD:    state_q <= HOLD;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_c7seg_capture.sv
// Purpose : scoreboard bench for c7seg_capture, using directed bus vectors and hand-computed outputs.
// Latency : each expected output is queued with the absolute cycle at which it must appear.
// Backpressure: none. The monitor pops one entry whenever the DUT output vector changes.
module tb_c7seg_capture;
  localparam int NDIG   = 4;
  localparam int STABLE = 4;
  localparam int LAT    = STABLE + 1;

  localparam logic [6:0] S_1 = 7'b1001111;
  localparam logic [6:0] S_2 = 7'b0010010;
  localparam logic [6:0] S_3 = 7'b0000110;
  localparam logic [6:0] S_8 = 7'b0000000;
  localparam logic [6:0] S_A = 7'b0001000;
  localparam logic [6:0] S_B = 7'b1100000;
  localparam logic [6:0] S_C = 7'b0110001;
  localparam logic [6:0] S_D = 7'b1000010;
  localparam logic [6:0] S_X = 7'b1010101;
  localparam logic [6:0] S_BLANK = 7'b1111111;

  logic              clk = 1'b0;
  logic              reset;
  logic [NDIG-1:0]   an;
  logic [6:0]        seg;
  logic [4*NDIG-1:0] o_digits;
  logic [NDIG-1:0]   o_valid;
  logic [NDIG-1:0]   o_err;
  logic              o_frame;

  c7seg_capture #(.NDIG(NDIG), .STABLE(STABLE)) dut (
    .clk      (clk),
    .reset    (reset),
    .an       (an),
    .seg      (seg),
    .o_digits (o_digits),
    .o_valid  (o_valid),
    .o_err    (o_err),
    .o_frame  (o_frame)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int          cyc;
    logic [15:0] dig;
    logic [3:0]  val;
    logic [3:0]  err;
    logic        frm;
  } exp_t;

  exp_t        q[$];
  int          cyc    = 0;
  int          total  = 0;
  int          bad    = 0;
  bit          mon_en = 1'b0;
  logic [24:0] prev   = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int at, input logic [15:0] d, input logic [3:0] v,
                      input logic [3:0] e, input logic f);
    exp_t x;
    x.cyc = at;
    x.dig = d;
    x.val = v;
    x.err = e;
    x.frm = f;
    q.push_back(x);
  endtask

  task automatic drive(input logic [3:0] a, input logic [6:0] s);
    an  = a;
    seg = s;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // The monitor takes every change of the output vector as one DUT response.
  always @(negedge clk) begin : monitor
    logic [24:0] now;
    exp_t        e;
    now = {o_digits, o_valid, o_err, o_frame};
    if (mon_en && (now !== prev)) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_change: got %h at cycle %0d, required no change", now, cyc);
      end else begin
        e = q.pop_front();
        if (cyc != e.cyc) begin
          bad++;
          $display("FAIL timing: output %h appeared at cycle %0d, required cycle %0d", now, cyc, e.cyc);
        end
        total++;
        if (now !== {e.dig, e.val, e.err, e.frm}) begin
          bad++;
          $display("FAIL outputs@%0d: got dig=%h val=%b err=%b frm=%b, required dig=%h val=%b err=%b frm=%b",
                   cyc, o_digits, o_valid, o_err, o_frame, e.dig, e.val, e.err, e.frm);
        end
      end
      prev = now;
    end
  end

  initial begin
    // Hold reset for three edges while a stable "1" is shown on digit 0.
    reset = 1'b0;
    drive(4'b1110, S_1);
    idle(3);
    total++;
    if ({o_digits, o_valid, o_err, o_frame} !== 25'd0) begin
      bad++;
      $display("FAIL reset_state: got %h, required 0", {o_digits, o_valid, o_err, o_frame});
    end
    prev   = '0;
    mon_en = 1'b1;
    reset  = 1'b1;
    push(cyc + LAT, 16'h0001, 4'b0001, 4'b0000, 1'b0);
    idle(10);

    // A "2" held for only three edges must be rejected; the "3" that follows is captured.
    drive(4'b1101, S_2);
    idle(3);
    drive(4'b1101, S_3);
    push(cyc + LAT, 16'h0031, 4'b0011, 4'b0000, 1'b0);
    idle(10);

    // Full scan A, b, C, d. The digit 3 capture completes the frame.
    drive(4'b1110, S_A);
    push(cyc + LAT, 16'h003A, 4'b0011, 4'b0000, 1'b0);
    idle(10);
    drive(4'b1101, S_B);
    push(cyc + LAT, 16'h00BA, 4'b0011, 4'b0000, 1'b0);
    idle(10);
    drive(4'b1011, S_C);
    push(cyc + LAT, 16'h0CBA, 4'b0111, 4'b0000, 1'b0);
    idle(10);
    drive(4'b0111, S_D);
    push(cyc + LAT,     16'hDCBA, 4'b1111, 4'b0000, 1'b1);
    push(cyc + LAT + 1, 16'hDCBA, 4'b1111, 4'b0000, 1'b0);
    idle(10);

    // Show an illegal pattern on digit 2, then a blank pattern on the same digit.
    drive(4'b1011, S_X);
    push(cyc + LAT, 16'hDCBA, 4'b1011, 4'b0100, 1'b0);
    idle(10);
    drive(4'b1011, S_BLANK);
    push(cyc + LAT, 16'hDCBA, 4'b1011, 4'b0000, 1'b0);
    idle(10);

    // Strobe faults: two low strobes, then no strobe. No output may change.
    drive(4'b1100, S_8);
    idle(20);
    drive(4'b1111, S_8);
    idle(20);

    // A long hold on digit 0 must produce a single capture.
    drive(4'b1110, S_8);
    push(cyc + LAT, 16'hDCB8, 4'b1011, 4'b0000, 1'b0);
    idle(50);

    // Frame pulses only when digits 1 and 3 are added to the restarted mask.
    drive(4'b1101, S_1);
    push(cyc + LAT, 16'hDC18, 4'b1011, 4'b0000, 1'b0);
    idle(10);
    drive(4'b0111, S_3);
    push(cyc + LAT,     16'h3C18, 4'b1011, 4'b0000, 1'b1);
    push(cyc + LAT + 1, 16'h3C18, 4'b1011, 4'b0000, 1'b0);
    idle(10);

    // Assert reset partway through a settle window.
    drive(4'b1110, S_1);
    idle(2);
    push(cyc + 1, 16'h0000, 4'b0000, 4'b0000, 1'b0);
    reset = 1'b0;
    idle(1);
    reset = 1'b1;
    push(cyc + LAT, 16'h0001, 4'b0001, 4'b0000, 1'b0);
    idle(10);

    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL missing_outputs: pending=%0d, required 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/c7seg_capture.md
Name: c7seg_capture

Overview:
- Receive-side counterpart of the team's hex-to-7-segment decoder: watches a multiplexed, active-low 7-segment display bus (digit strobes plus segment lines) and recovers the 4-bit hex value shown on each digit.
- Used for board self-check and simulation readback of display controllers.
- Each value is captured only after the bus has been stable for a qualifying interval.

Parameters:
- NDIG, 4, number of multiplexed digits (1..8).
- STABLE, 4, consecutive cycles the sampled bus must be unchanged before capture (1..255).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low reset.
- an  input  NDIG  digit strobes, active-low; bit i selects digit i.
- seg  input  7  segment lines, active-low; bit6=a, bit5=b, bit4=c, bit3=d, bit2=e, bit1=f, bit0=g.
- o_digits  output  4*NDIG  recovered hex values; digit i is in bits [4i+3:4i].
- o_valid  output  NDIG  digit i currently holds a legally decoded value.
- o_err  output  NDIG  last capture on digit i was an illegal, non-blank pattern.
- o_frame  output  1  one-cycle pulse: every digit has been captured since the last pulse.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low.
  - While reset=0 at a rising edge, all outputs are cleared: o_digits=0, o_valid=0, o_err=0, o_frame=0.
  - Also cleared: input registers, stability counter, update mask, FSM → IDLE.
  - Reset asserted mid-count or mid-hold discards everything; no partial capture.
- Input stage and stability counter:
  - r_an/r_seg register an/seg every cycle.
  - cnt (8 bits, saturating) clears when {an,seg} != {r_an,r_seg}; otherwise increments.
- Single-strobe rule: capture is only legal when r_an has exactly one zero bit. All-ones (no digit) or more than one zero → FSM to IDLE, no capture.
- FSM:
  - IDLE: single strobe → SETTLE.
  - SETTLE: capture on the edge where cnt==STABLE-1 and inputs still equal r → HOLD. Any input change → cnt clears and FSM stays in SETTLE; an invalid strobe → IDLE.
  - HOLD: exactly one capture per stable window. Any input change → SETTLE (or IDLE if the new strobe is invalid). Continuous stability never re-captures.
- Latency: inputs changing before edge E and then held produce updated outputs after edge E+STABLE (STABLE+1 rising edges).
- Decode (inverse of the team decoder table, seg as a..g active-low):
  - 0000001→0, 1001111→1, 0010010→2, 0000110→3, 1001100→4, 0100100→5, 0100000→6, 0001111→7, 0000000→8, 0000100→9, 0001000→A, 1100000→b, 0110001→C, 1000010→d, 0110000→E, 0111000→F.
- Capture on digit i:
  - Legal pattern: o_digits[i]=value, o_valid[i]=1, o_err[i]=0.
  - Blank (1111111): o_valid[i]=0, o_err[i]=0, o_digits[i] keeps its old value.
  - Any other pattern: o_err[i]=1, o_valid[i]=0, o_digits[i] keeps its old value.
  - Other digits are unaffected.
- Frame logic:
  - Every capture (legal, blank or error) sets mask[i].
  - When a capture makes the mask all ones, o_frame=1 on that same edge's output for one cycle, and the mask clears to 0, with the capturing digit not re-set.
  - NDIG=1: every capture pulses o_frame.
- Output timing: all outputs registered; o_frame is never high two consecutive cycles.

Test Plan:
- Reset: hold reset=0 for 3 cycles with an=1110, seg=1001111 → all outputs 0; release → o_digits[0]=1, o_valid=0001 after 5 edges (STABLE=4), not earlier.
- Glitch rejection: an=1101, seg=0010010 for 3 cycles, then seg=0000110 held → no capture of 2; digit1=3 appears 5 edges after the change; o_err=0.
- Full scan: cycle an 1110/1101/1011/0111 with patterns for A, b, C, d, each held 10 cycles → o_digits=16'hDCBA, o_valid=1111, o_frame high exactly one cycle after the digit3 capture, mask restarts.
- Illegal/blank: digit2 shows 1010101 → o_err=0100, o_valid[2]=0, o_digits[11:8] unchanged; then 1111111 → o_err[2]=0, o_valid[2]=0.
- Strobe faults: an=1100 or an=1111 held 20 cycles with seg=0000000 → no output change, no o_frame.
- No re-capture: an=1110, seg=0000000 held 50 cycles → exactly one capture and one mask set; reset asserted at cycle 2 of a later SETTLE → outputs cleared and nothing captured at the next edge.
